// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin / fixed-priority arbitrated mux with registered output
//
// Selects one valid/ready input stream per cycle and captures the winner in a
// single output register that honours downstream backpressure.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   IN_DATA    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   IN_VALID   per-channel valid
//   IN_READY   per-channel accept, at most one bit high
//   PRIO_MODE  0 = round-robin, 1 = fixed priority (lowest index wins)
//   OUT_DATA   registered winning data
//   OUT_SEL    index of the channel that supplied OUT_DATA
//   OUT_VALID  output register holds a beat
//   OUT_READY  downstream accepts the beat

module rr_arb_mux #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]       IN_VALID,
   output logic [CHANNELS-1:0]       IN_READY,
   input  logic                      PRIO_MODE,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic [SEL_W-1:0]          OUT_SEL,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   data_q;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   last_q;

   logic               load_en;
   logic               gnt_found;
   logic [SEL_W-1:0]   gnt_idx;

   // The register can take a new beat when it is empty or being drained.
   assign load_en = (state_q == EMPTY) || OUT_READY;

   // Grant search. Loops run from the lowest-priority candidate upwards so
   // the last assignment made is the highest-priority valid channel.
   always_comb begin
      int                idx;
      logic [SEL_W-1:0]  cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      cand      = '0;
      if (PRIO_MODE) begin
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (IN_VALID[i]) begin
               gnt_found = 1'b1;
               gnt_idx   = SEL_W'(i);
            end
         end
      end else begin
         // Candidate at distance k after LAST; k = CHANNELS revisits LAST itself.
         for (int k = CHANNELS; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= CHANNELS) begin
               idx = idx - CHANNELS;
            end
            cand = SEL_W'(idx);
            if (IN_VALID[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      IN_READY = '0;
      if (load_en && gnt_found) begin
         IN_READY[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load_en) begin
         state_d = gnt_found ? FULL : EMPTY;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Data, index and pointer move only on an actual input transfer; an idle
   // load slot just empties the register and leaves these holding.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_q <= '0;
         sel_q  <= '0;
         last_q <= SEL_W'(CHANNELS - 1);
      end else if (load_en && gnt_found) begin
         data_q <= IN_DATA[gnt_idx*WIDTH +: WIDTH];
         sel_q  <= gnt_idx;
         last_q <= gnt_idx;
      end
   end

   assign OUT_DATA  = data_q;
   assign OUT_SEL   = sel_q;
   assign OUT_VALID = (state_q == FULL);

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scoreboard testbench for rr_arb_mux

module tb_rr_arb_mux;

   localparam int WIDTH    = 32;
   localparam int CHANNELS = 4;
   localparam int SEL_W    = 2;

   logic                      CLK;
   logic                      RST;
   logic [CHANNELS*WIDTH-1:0] IN_DATA;
   logic [CHANNELS-1:0]       IN_VALID;
   logic [CHANNELS-1:0]       IN_READY;
   logic                      PRIO_MODE;
   logic [WIDTH-1:0]          OUT_DATA;
   logic [SEL_W-1:0]          OUT_SEL;
   logic                      OUT_VALID;
   logic                      OUT_READY;

   typedef struct {
      logic [SEL_W-1:0] sel;
      logic [WIDTH-1:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   rr_arb_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .PRIO_MODE (PRIO_MODE),
      .OUT_DATA  (OUT_DATA),
      .OUT_SEL   (OUT_SEL),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_ch(input int ch);
      beat_t b;
      b.sel  = SEL_W'(ch);
      b.data = 32'hA000_0000 + ch;
      exp_q.push_back(b);
   endtask

   task automatic set_default_data();
      for (int i = 0; i < CHANNELS; i++) begin
         IN_DATA[i*WIDTH +: WIDTH] = 32'hA000_0000 + i;
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: one beat leaves the register per negedge where valid and ready meet.
   always @(negedge CLK) begin
      if (RST) begin
         chk("ready_onehot0", 64'($onehot0(IN_READY)), 64'd1);
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat_sel", 64'(OUT_SEL), 64'hFF);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_sel", 64'(OUT_SEL), 64'(b.sel));
               chk("beat_data", 64'(OUT_DATA), 64'(b.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST       = 1'b0;
      IN_VALID  = '0;
      PRIO_MODE = 1'b0;
      OUT_READY = 1'b1;
      set_default_data();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
      chk("rst_out_data", 64'(OUT_DATA), 64'd0);
      chk("rst_out_sel", 64'(OUT_SEL), 64'd0);
      chk("rst_in_ready", 64'(IN_READY), 64'd0);
      RST = 1'b1;
      step();

      // 1: round-robin, all valid, streaming
      IN_VALID = 4'b1111;
      for (int i = 0; i < 8; i++) push_ch(i % 4);
      @(negedge CLK);
      chk("t1_first_ready", 64'(IN_READY), 64'b0001);
      chk("t1_valid_before_xfer", 64'(OUT_VALID), 64'd0);
      step();
      chk("t1_valid_after_xfer", 64'(OUT_VALID), 64'd1);
      repeat (7) step();
      IN_VALID = 4'b0000;
      step();
      @(negedge CLK);
      chk("t5_idle_valid_low", 64'(OUT_VALID), 64'd0);
      step();

      // 2: backpressure (LAST = 3, so ch0 then ch1)
      IN_VALID = 4'b1111;
      push_ch(0);
      step();
      OUT_READY = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         chk("t2_hold_data", 64'(OUT_DATA), 64'hA000_0000);
         chk("t2_hold_ready", 64'(IN_READY), 64'b0000);
         chk("t2_hold_valid", 64'(OUT_VALID), 64'd1);
         step();
      end
      OUT_READY = 1'b1;
      push_ch(1);
      @(negedge CLK);
      chk("t2_resume_ready", 64'(IN_READY), 64'b0010);
      step();
      IN_VALID = 4'b0000;
      repeat (2) step();

      // 3: fixed priority, ch1 starves ch3
      PRIO_MODE = 1'b1;
      IN_VALID  = 4'b1010;
      repeat (4) begin
         push_ch(1);
         @(negedge CLK);
         chk("t3_fp_ready", 64'(IN_READY), 64'b0010);
         step();
      end
      IN_VALID = 4'b1000;
      push_ch(3);
      @(negedge CLK);
      chk("t3_fp_ch3_ready", 64'(IN_READY), 64'b1000);
      step();
      IN_VALID = 4'b0000;
      repeat (2) step();

      // 4: round-robin wrap-around
      PRIO_MODE = 1'b0;
      IN_VALID  = 4'b1000;
      push_ch(3);
      step();
      IN_VALID = 4'b0101;
      push_ch(0);
      push_ch(2);
      push_ch(0);
      repeat (3) step();
      IN_VALID = 4'b0000;
      repeat (2) step();

      // 5: single pulse on ch2 with distinct data
      begin
         beat_t b;
         IN_DATA[2*WIDTH +: WIDTH] = 32'h1234_5678;
         IN_VALID = 4'b0100;
         b.sel  = 2'd2;
         b.data = 32'h1234_5678;
         exp_q.push_back(b);
         step();
         IN_VALID = 4'b0000;
         chk("t5_pulse_valid", 64'(OUT_VALID), 64'd1);
         chk("t5_pulse_sel", 64'(OUT_SEL), 64'd2);
         chk("t5_pulse_data", 64'(OUT_DATA), 64'h1234_5678);
         set_default_data();
         repeat (2) step();
      end

      // 6: asynchronous reset with a held beat (LAST = 2, so ch3 is captured)
      OUT_READY = 1'b0;
      IN_VALID  = 4'b1111;
      step();
      IN_VALID = 4'b0000;
      chk("t6_pre_valid", 64'(OUT_VALID), 64'd1);
      chk("t6_pre_sel", 64'(OUT_SEL), 64'd3);
      #2;
      RST = 1'b0;
      #1;
      chk("t6_async_valid", 64'(OUT_VALID), 64'd0);
      chk("t6_async_data", 64'(OUT_DATA), 64'd0);
      chk("t6_async_sel", 64'(OUT_SEL), 64'd0);
      step();
      RST       = 1'b1;
      OUT_READY = 1'b1;
      IN_VALID  = 4'b1111;
      push_ch(0);
      @(negedge CLK);
      chk("t6_first_grant", 64'(IN_READY), 64'b0001);
      step();
      IN_VALID = 4'b0000;
      repeat (3) step();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrated multiplexer with a registered output. Successor to the fixed-width structural selection muxes.
- Selects one of CHANNELS valid/ready input streams per cycle, using round-robin or fixed-priority arbitration.
- Drives the winner through a single output register with backpressure.
- Used wherever several producers share one datapath, e.g. register-file write-back or memory request merge.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of input channels; must be ≥2.
- SEL_W, 2, width of the channel index; must equal ceil(log2(CHANNELS)).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- IN_DATA  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  input  CHANNELS  per-channel data valid.
- IN_READY  output  CHANNELS  per-channel accept; at most one bit is high per cycle.
- PRIO_MODE  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- OUT_DATA  output  WIDTH  registered winning data.
- OUT_SEL  output  SEL_W  index of the channel that supplied OUT_DATA.
- OUT_VALID  output  1  output register holds a beat.
- OUT_READY  input  1  downstream accepts the beat.

Behaviour:
- Reset (RST low, asynchronous):
  - OUT_VALID=0, OUT_DATA=0, OUT_SEL=0.
  - Round-robin pointer LAST=CHANNELS-1, so channel 0 has first priority.
  - Reset asserted mid-transfer discards the held beat immediately.
- Output register state: EMPTY (OUT_VALID=0) or FULL (OUT_VALID=1).
- load_en = !OUT_VALID || OUT_READY. Arbitration happens only when load_en=1.
- Grant is combinational from IN_VALID, PRIO_MODE, LAST and load_en:
  - Round-robin: first valid channel searching LAST+1, LAST+2, … with wrap at CHANNELS-1 → 0.
  - Fixed priority: lowest-index valid channel.
  - IN_READY[g]=1 only for the granted channel g, only when load_en=1. All other bits are 0.
- Transfer on input g = IN_VALID[g] && IN_READY[g]. On that clock edge:
  - OUT_DATA←IN_DATA[g], OUT_SEL←g, OUT_VALID←1.
  - LAST←g. LAST updates in both modes.
- load_en=1 with no IN_VALID bit set: OUT_VALID←0; OUT_DATA/OUT_SEL hold their previous values; LAST unchanged.
- Timing:
  - Latency is one cycle from input transfer to OUT_VALID.
  - Throughput is one beat per cycle when OUT_READY stays high.
  - Back-to-back transfers are allowed: a simultaneous output drain and input load in the same cycle is legal.
- Backpressure: OUT_VALID=1 && OUT_READY=0 → all IN_READY=0; OUT_DATA, OUT_SEL and LAST stable.
- A PRIO_MODE change takes effect at the next arbitration. There is no flush and no effect on a held beat.
- IN_VALID may drop without a transfer; producers are not required to hold valid.
- No combinational path from IN_DATA to OUT_DATA. The only combinational path to IN_READY is from IN_VALID, OUT_VALID, OUT_READY, PRIO_MODE and LAST.
- The arbitration search must be generic in CHANNELS. No hard-coded 4-way logic.

Test Plan:
(CHANNELS=4, WIDTH=32; IN_DATA channel i = 0xA000_0000+i unless noted.)
1. Round-robin, all IN_VALID=4'b1111, OUT_READY=1 constant after reset:
   - OUT_SEL sequence 0,1,2,3,0,1… one beat per cycle.
   - First OUT_VALID one cycle after the first transfer.
   - OUT_DATA=0xA000_0000…0xA000_0003 in order.
2. Backpressure:
   - After the first beat (ch0) is captured, hold OUT_READY=0 for 3 cycles → OUT_DATA=0xA000_0000 stable and IN_READY=4'b0000 throughout.
   - On OUT_READY=1 the next beat is ch1; no channel is skipped.
3. Fixed priority, PRIO_MODE=1, IN_VALID=4'b1010:
   - Ch1 is granted every cycle and ch3 is starved.
   - Clear IN_VALID[1] → ch3 is granted on the next cycle.
4. Wrap-around, round-robin:
   - Preload LAST=3 by granting ch3 alone, then IN_VALID=4'b0101 → grant order is ch0, then ch2, then ch0.
5. Idle and sparse traffic:
   - IN_VALID=0 with OUT_READY=1 → OUT_VALID falls to 0 one cycle after the last beat drains.
   - A single pulse on ch2 with IN_DATA=0x1234_5678 → OUT_VALID=1, OUT_SEL=2, OUT_DATA=0x1234_5678 exactly one cycle later.
6. Asynchronous reset:
   - Assert RST=0 mid-cycle while OUT_VALID=1 and OUT_READY=0 → OUT_VALID=0 and OUT_DATA=0 before the next clock edge.
   - After release with all channels valid, the first grant is ch0.
